lfsr_parity_checker: RTL and testbench



---
 rtl/lfsr_parity_checker_pkg.sv | 21 ++
 rtl/lfsr_parity_checker_sat_counter.sv | 21 ++
 rtl/lfsr_parity_checker.sv | 118 +++++++++++
 tb/tb_lfsr_parity_checker.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_parity_checker_pkg.sv
// Shared PRBS7 constants, checker state type and the LFSR step function
// used by both the pattern generator and the receive-side checker.
package lfsr_parity_checker_pkg;

    localparam int unsigned           PRBS_WIDTH = 7;
    localparam logic [PRBS_WIDTH-1:0] PRBS_TAPS  = 7'h60;
    localparam int unsigned           PAR_BIT    = 7;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } chk_state_t;

    // One Fibonacci step: shift left, feedback bit enters at the LSB.
    function automatic logic [PRBS_WIDTH-1:0] next_state(input logic [PRBS_WIDTH-1:0] cur);
        logic fb;
        fb = ^(cur & PRBS_TAPS);
        return {cur[PRBS_WIDTH-2:0], fb};
    endfunction

endpackage

// File: rtl/lfsr_parity_checker_sat_counter.sv
// Width-parameterised saturating event counter with synchronous clear.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Clear wins over a coincident increment; increments stop at all-ones.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/lfsr_parity_checker.sv
// Receive-side PRBS7+parity checker: per-word parity check, self-synchronising
// sequence lock, error pulses and saturating error counters.
module lfsr_parity_checker
    import lfsr_parity_checker_pkg::*;
#(
    parameter int unsigned      WIDTH      = PRBS_WIDTH,
    parameter logic [WIDTH-1:0] TAPS       = PRBS_TAPS,
    parameter int unsigned      LOCK_CNT   = 4,
    parameter int unsigned      UNLOCK_CNT = 3,
    parameter int unsigned      CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH:0]   in_data,
    input  logic             in_valid,
    input  logic             clr_cnt,
    output logic             parity_err,
    output logic             seq_err,
    output logic             locked,
    output logic [CNT_W-1:0] par_err_count,
    output logic [CNT_W-1:0] seq_err_count
);

    localparam int unsigned MC_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned MS_W = $clog2(UNLOCK_CNT + 1);
    localparam logic [MC_W-1:0] LOCK_LAST   = MC_W'(LOCK_CNT - 1);
    localparam logic [MS_W-1:0] UNLOCK_LAST = MS_W'(UNLOCK_CNT - 1);

    chk_state_t       state;
    logic [MC_W-1:0]  match_cnt;
    logic [MS_W-1:0]  miss_cnt;
    logic [WIDTH-1:0] prev;
    logic             prev_valid;

    logic [WIDTH-1:0] lf;
    logic [WIDTH-1:0] pred;
    logic             par_bad;
    logic             match;
    logic             par_inc;
    logic             seq_inc;

    // Prediction from the previous word and the per-word error decisions.
    always_comb begin
        lf      = in_data[WIDTH-1:0];
        pred    = {prev[WIDTH-2:0], ^(prev & TAPS)};
        par_bad = in_data[WIDTH] != ^lf;
        match   = prev_valid && (lf == pred) && (lf != '0);
        par_inc = in_valid && par_bad;
        seq_inc = in_valid && (state == LOCKED) && !match;
    end

    // Lock FSM, previous-word history and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SEARCH;
            match_cnt  <= '0;
            miss_cnt   <= '0;
            prev       <= '0;
            prev_valid <= 1'b0;
            parity_err <= 1'b0;
            seq_err    <= 1'b0;
            locked     <= 1'b0;
        end else begin
            parity_err <= par_inc;
            seq_err    <= seq_inc;
            if (in_valid) begin
                // Every sampled word becomes history, even a corrupted one.
                prev       <= lf;
                prev_valid <= 1'b1;
                unique case (state)
                    SEARCH: begin
                        if (match) begin
                            if (match_cnt == LOCK_LAST) begin
                                state     <= LOCKED;
                                match_cnt <= '0;
                                miss_cnt  <= '0;
                                locked    <= 1'b1;
                            end else begin
                                match_cnt <= match_cnt + 1'b1;
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        if (match) begin
                            miss_cnt <= '0;
                        end else if (miss_cnt == UNLOCK_LAST) begin
                            state     <= SEARCH;
                            miss_cnt  <= '0;
                            match_cnt <= '0;
                            locked    <= 1'b0;
                        end else begin
                            miss_cnt <= miss_cnt + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_par_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_cnt),
        .inc   (par_inc),
        .count (par_err_count)
    );

    sat_counter #(.W(CNT_W)) u_seq_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_cnt),
        .inc   (seq_inc),
        .count (seq_err_count)
    );

endmodule

// File: tb/tb_lfsr_parity_checker.sv
// Bench for lfsr_parity_checker: a default instance and a CNT_W=2 instance
// share one stimulus stream and are compared against an abstract model.
module tb_lfsr_parity_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        clr_cnt;

    logic        pe_a, se_a, lk_a;
    logic [15:0] pc_a, sc_a;
    logic        pe_b, se_b, lk_b;
    logic [1:0]  pc_b, sc_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lfsr_parity_checker dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .clr_cnt(clr_cnt),
        .parity_err(pe_a), .seq_err(se_a), .locked(lk_a),
        .par_err_count(pc_a), .seq_err_count(sc_a)
    );

    lfsr_parity_checker #(.CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .clr_cnt(clr_cnt),
        .parity_err(pe_b), .seq_err(se_b), .locked(lk_b),
        .par_err_count(pc_b), .seq_err_count(sc_b)
    );

    // ---------------- reference model ----------------
    bit m_locked, m_have_prev, m_pe, m_se;
    int m_prev, m_run, m_par, m_seq;

    function automatic int prbs_next(input int x);
        return ((x * 2) % 128) + ((((x / 64) % 2) + ((x / 32) % 2)) % 2);
    endfunction

    function automatic logic [7:0] mk_word(input int lf, input bit flip);
        int ones;
        ones = $countones(lf[6:0]);
        return 8'(((((ones % 2) != 0) ^ flip) ? 128 : 0) + lf);
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic model_step(input bit v, input logic [7:0] d, input bit c, input bit r);
        int lf;
        bit good, bad;
        m_pe = 0;
        m_se = 0;
        if (r) begin
            m_locked = 0; m_have_prev = 0; m_prev = 0; m_run = 0; m_par = 0; m_seq = 0;
            return;
        end
        if (v) begin
            lf   = int'(d[6:0]);
            bad  = ($countones(d) % 2) != 0;
            good = m_have_prev && lf == prbs_next(m_prev) && lf != 0;
            if (bad) begin m_pe = 1; m_par++; end
            if (!m_locked) begin
                m_run = good ? m_run + 1 : 0;
                if (m_run == 4) begin m_locked = 1; m_run = 0; end
            end else if (good) begin
                m_run = 0;
            end else begin
                m_se = 1; m_seq++; m_run++;
                if (m_run == 3) begin m_locked = 0; m_run = 0; end
            end
            m_prev = lf;
            m_have_prev = 1;
        end
        if (c) begin m_par = 0; m_seq = 0; end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, then compare both instances with the model.
    task automatic cycle(input bit v, input logic [7:0] d, input bit c, input bit r);
        rst = r; in_valid = v; in_data = d; clr_cnt = c;
        @(posedge clk);
        #1;
        model_step(v, d, c, r);
        chk("parity_err",       int'(pe_a), int'(m_pe));
        chk("seq_err",          int'(se_a), int'(m_se));
        chk("locked",           int'(lk_a), int'(m_locked));
        chk("par_err_count",    int'(pc_a), sat(m_par, 65535));
        chk("seq_err_count",    int'(sc_a), sat(m_seq, 65535));
        chk("small.parity_err", int'(pe_b), int'(m_pe));
        chk("small.seq_err",    int'(se_b), int'(m_se));
        chk("small.locked",     int'(lk_b), int'(m_locked));
        chk("small.par_count",  int'(pc_b), sat(m_par, 3));
        chk("small.seq_count",  int'(sc_b), sat(m_seq, 3));
    endtask

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       se;
        logic       lk;
    } vec_t;

    vec_t tbl[5];
    int gen;
    int sc0;
    int garbage[3];

    initial begin
        tbl[0] = '{8'h81, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{8'h82, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{8'h84, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{8'h88, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{8'h90, 1'b0, 1'b0, 1'b1};
        garbage[0] = 'h00; garbage[1] = 'h55; garbage[2] = 'h33;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; clr_cnt = 1'b0;
        @(posedge clk); #1;
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("reset.locked", int'(lk_a), 0);
        chk("reset.par_err_count", int'(pc_a), 0);

        // Acquire lock from a clean stream.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, tbl[i].d, 1'b0, 1'b0);
            chk("tbl.parity_err", int'(pe_a), int'(tbl[i].pe));
            chk("tbl.seq_err",    int'(se_a), int'(tbl[i].se));
            chk("tbl.locked",     int'(lk_a), int'(tbl[i].lk));
        end
        chk("lock.counts", int'(pc_a) + int'(sc_a), 0);
        gen = 'h10;

        // Correct LFSR field with wrong parity bit: parity error only.
        gen = prbs_next(gen); cycle(1'b1, mk_word(gen, 0), 1'b0, 1'b0);
        gen = prbs_next(gen); cycle(1'b1, mk_word(gen, 1), 1'b0, 1'b0);
        chk("parflip.parity_err", int'(pe_a), 1);
        chk("parflip.seq_err",    int'(se_a), 0);
        chk("parflip.count",      int'(pc_a), 1);
        gen = prbs_next(gen); cycle(1'b1, mk_word(gen, 0), 1'b0, 1'b0);
        chk("parflip.resume_seq_err", int'(se_a), 0);

        // One corrupted word costs two mismatches but keeps lock.
        sc0 = int'(sc_a);
        cycle(1'b1, 8'hFF, 1'b0, 1'b0);
        chk("corrupt.seq_err1", int'(se_a), 1);
        gen = prbs_next(gen); cycle(1'b1, mk_word(gen, 0), 1'b0, 1'b0);
        chk("corrupt.seq_err2", int'(se_a), 1);
        gen = prbs_next(gen); cycle(1'b1, mk_word(gen, 0), 1'b0, 1'b0);
        chk("corrupt.seq_err3", int'(se_a), 0);
        chk("corrupt.count",    int'(sc_a) - sc0, 2);
        chk("corrupt.locked",   int'(lk_a), 1);

        // Three unrelated words drop lock; five good words regain it.
        for (int i = 0; i < 3; i++) cycle(1'b1, mk_word(garbage[i], 0), 1'b0, 1'b0);
        chk("unlock.locked", int'(lk_a), 0);
        for (int i = 0; i < 5; i++) begin
            gen = prbs_next(gen); cycle(1'b1, mk_word(gen, 0), 1'b0, 1'b0);
        end
        chk("relock.locked", int'(lk_a), 1);

        // Valid gap is transparent.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 8'($urandom), 1'b0, 1'b0);
            chk("gap.pulses", int'(pe_a) + int'(se_a), 0);
        end
        gen = prbs_next(gen); cycle(1'b1, mk_word(gen, 0), 1'b0, 1'b0);
        chk("gap.seq_err", int'(se_a), 0);
        chk("gap.locked",  int'(lk_a), 1);

        // Saturation on the narrow instance, then clear against an error.
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            gen = prbs_next(gen); cycle(1'b1, mk_word(gen, 1), 1'b0, 1'b0);
        end
        chk("sat.small_count", int'(pc_b), 3);
        chk("sat.wide_count",  int'(pc_a), 5);
        gen = prbs_next(gen); cycle(1'b1, mk_word(gen, 1), 1'b1, 1'b0);
        chk("clr.parity_err",  int'(pe_b), 1);
        chk("clr.small_count", int'(pc_b), 0);
        chk("clr.wide_count",  int'(pc_a), 0);

        // Randomized stream: mostly correct, with corruptions, gaps, clears, resets.
        for (int n = 0; n < 3000; n++) begin
            int k;
            bit v, c, r;
            logic [7:0] w;
            k = $urandom_range(0, 999);
            r = (k < 5);
            c = ($urandom_range(0, 99) < 2);
            v = ($urandom_range(0, 7) != 0);
            if (k >= 5 && k < 25) begin
                for (int g = 0; g < 3; g++)
                    cycle(1'b1, mk_word($urandom_range(0, 127), 0), 1'b0, 1'b0);
            end
            k = $urandom_range(0, 99);
            if (k < 80) begin
                gen = prbs_next(gen); w = mk_word(gen, 0);
            end else if (k < 88) begin
                gen = prbs_next(gen); w = mk_word(gen, 1);
            end else if (k < 95) begin
                w = 8'($urandom);
            end else begin
                w = 8'h00;
            end
            if (gen == 0) gen = 1;
            cycle(v, w, c, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
